cfg_dispatcher: RTL

Upstream command stage for the PE-array accelerator (`test`). It accepts configuration commands from the host as a stream of narrow words, assembles them into the four accelerator configuration fields, and buffers them in a small FIFO. It then issues each command through the accelerator's `cfg_valid`/`cfg_busy` handshake, one command at a time, and never issues while the accelerator is busy.

---
 rtl/cfg_dispatcher.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cfg_dispatcher.sv
// cfg_fifo: generic first-in first-out buffer with occupancy count, head visible combinationally.
// Latency: a push is visible at the head on the cycle after the push edge; level updates at the same edge.
// Backpressure: none internally; the producer must not push when full, the consumer must not pop when empty.
module cfg_fifo #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int LWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [WIDTH-1:0]  push_dat,
    input  logic              pop_vld,
    output logic [WIDTH-1:0]  head_dat,
    output logic [LWIDTH-1:0] level,
    output logic              empty,
    output logic              full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];
    assign empty    = (level == '0);
    assign full     = (level == LWIDTH'(DEPTH));

    // Storage array: written on push only, contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two; level tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   level <= level + LWIDTH'(1);
                2'b01:   level <= level - LWIDTH'(1);
                default: level <= level;
            endcase
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) push_vld |-> !full);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop_vld |-> !empty);

endmodule

// cfg_dispatcher: assembles host words into accelerator config commands, buffers them, issues one at a time.
// Latency: final host word at edge T -> cfg_valid high in the cycle after edge T+1 (when idle, busy low); issues spaced >= 3 cycles.
// Backpressure: host_ready drops only on the last word of a command while the FIFO is full; no issue while cfg_busy is high.
module cfg_dispatcher #(
    parameter  int DATA_CWIDTH = 64,
    parameter  int WICP_CWIDTH = 32,
    parameter  int TMPC_CWIDTH = 32,
    parameter  int POST_CWIDTH = 32,
    parameter  int HWIDTH      = 32,
    parameter  int DEPTH       = 4,
    localparam int LWIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [HWIDTH-1:0]      host_data,
    output logic                   cfg_valid,
    input  logic                   cfg_busy,
    output logic [DATA_CWIDTH-1:0] cfg_data_data,
    output logic [WICP_CWIDTH-1:0] cfg_wicp_data,
    output logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
    output logic [POST_CWIDTH-1:0] cfg_post_data,
    output logic [LWIDTH-1:0]      buf_level,
    output logic [15:0]            issue_cnt,
    output logic                   idle
);

    localparam int CWIDTH = DATA_CWIDTH + WICP_CWIDTH + TMPC_CWIDTH + POST_CWIDTH;
    localparam int NWORDS = (CWIDTH + HWIDTH - 1) / HWIDTH;
    localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int WICP_LSB = DATA_CWIDTH;
    localparam int TMPC_LSB = DATA_CWIDTH + WICP_CWIDTH;
    localparam int POST_LSB = DATA_CWIDTH + WICP_CWIDTH + TMPC_CWIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                     state;
    logic [IW-1:0]              word_idx;
    logic [NWORDS*HWIDTH-1:0]   partial;
    logic [NWORDS*HWIDTH-1:0]   assembled;
    logic                       last_word;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [CWIDTH-1:0]          head;

    // Stall only the word that would complete a command into a full FIFO; a pop in the same cycle is not credited.
    assign last_word  = (word_idx == IW'(NWORDS - 1));
    assign host_ready = !(last_word && fifo_full);
    assign accept     = host_valid && host_ready;
    assign push       = accept && last_word;

    // A pop is the transition into ISSUE: from IDLE or from WAIT once the accelerator reports not busy.
    assign pop = !fifo_empty && !cfg_busy && ((state == S_IDLE) || (state == S_WAIT));

    assign idle = fifo_empty && (word_idx == '0) && (state == S_IDLE) && !cfg_busy;

    // Full command = earlier words held in partial, final word taken straight from the host bus.
    always_comb begin
        assembled = partial;
        assembled[(NWORDS-1)*HWIDTH +: HWIDTH] = host_data;
    end

    // Word assembler: steer each accepted word into its slot and step the word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
            partial  <= '0;
        end else if (accept) begin
            for (int k = 0; k < NWORDS - 1; k++) begin
                if (word_idx == IW'(k)) begin
                    partial[k*HWIDTH +: HWIDTH] <= host_data;
                end
            end
            word_idx <= last_word ? '0 : word_idx + IW'(1);
        end
    end

    cfg_fifo #(
        .WIDTH (CWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (assembled[CWIDTH-1:0]),
        .pop_vld  (pop),
        .head_dat (head),
        .level    (buf_level),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Issue FSM with registered strobe, fields and counter; fields load only on entry to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cfg_valid     <= 1'b0;
            cfg_data_data <= '0;
            cfg_wicp_data <= '0;
            cfg_tmpc_data <= '0;
            cfg_post_data <= '0;
            issue_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE:  if (pop) state <= S_ISSUE;
                S_ISSUE: state <= S_GUARD;
                S_GUARD: state <= S_WAIT;
                S_WAIT:  if (!cfg_busy) state <= fifo_empty ? S_IDLE : S_ISSUE;
                default: state <= S_IDLE;
            endcase
            cfg_valid <= pop;
            if (pop) begin
                cfg_data_data <= head[DATA_CWIDTH-1:0];
                cfg_wicp_data <= head[WICP_LSB +: WICP_CWIDTH];
                cfg_tmpc_data <= head[TMPC_LSB +: TMPC_CWIDTH];
                cfg_post_data <= head[POST_LSB +: POST_CWIDTH];
                issue_cnt     <= issue_cnt + 16'd1;
            end
        end
    end

    a_valid_gap: assert property (@(posedge clk) disable iff (!rst_n) cfg_valid |=> !cfg_valid);

endmodule
